// File: rtl/bop_pkg.sv
// Shared types and constants for the buffer-overflow-protection interval table.
package bop_pkg;

   localparam int BOP_TABLE_DEPTH = 8;
   localparam int BOP_EVICT_W     = 16;
   localparam int BOP_AW          = 32;

   typedef struct packed {
      logic [BOP_AW-1:0] first;
      logic [BOP_AW-1:0] last;
   } bop_interval_t;

endpackage

// File: rtl/bop_range_cmp.sv
// Per-entry comparator: range/first-byte match for the lookup address and
// exact-pair match against the incoming write, used for duplicate suppression.
module bop_range_cmp
   import bop_pkg::*;
(
   input  logic              i_valid,
   input  bop_interval_t     i_entry,
   input  logic [BOP_AW-1:0] i_addr,
   input  bop_interval_t     i_wr_pair,
   output logic              o_in_range,
   output logic              o_is_first,
   output logic              o_dup
);

   // Plain unsigned compares: an interval never wraps through address 0.
   assign o_in_range = i_valid && (i_addr >= i_entry.first) && (i_addr <= i_entry.last);
   assign o_is_first = i_valid && (i_addr == i_entry.first);
   assign o_dup      = i_valid && (i_entry == i_wr_pair);

endmodule

// File: rtl/bop_interval_table.sv
// Circular table of overflow intervals with a combinational lookup port.
// AW must equal bop_pkg::BOP_AW, since entries are stored as bop_interval_t.
module bop_interval_table
   import bop_pkg::*;
#(
   parameter int DEPTH = BOP_TABLE_DEPTH,
   parameter int AW    = BOP_AW
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     wr_en_i,
   input  logic [AW-1:0]            wr_first_i,
   input  logic [AW-1:0]            wr_last_i,
   input  logic [AW-1:0]            lookup_addr_i,
   output logic                     in_range_o,
   output logic                     is_first_o,
   output logic [$clog2(DEPTH)-1:0] hit_idx_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [BOP_EVICT_W-1:0]   evict_cnt_o,
   output logic                     bad_wr_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]       r_valid;
   bop_interval_t          r_entry [DEPTH];
   logic [IDX_W-1:0]       r_wp;
   logic [CNT_W-1:0]       r_count;
   logic [BOP_EVICT_W-1:0] r_evict;
   logic                   r_bad;

   bop_interval_t          w_wr_pair;
   logic [DEPTH-1:0]       w_in_range;
   logic [DEPTH-1:0]       w_is_first;
   logic [DEPTH-1:0]       w_dup;
   logic                   w_ordered;
   logic                   w_write;
   logic                   w_full;
   logic [IDX_W-1:0]       w_hit_idx;

   assign w_wr_pair = '{first: wr_first_i, last: wr_last_i};
   assign w_ordered = (wr_first_i <= wr_last_i);
   assign w_write   = wr_en_i && !flush_i && w_ordered && !(|w_dup);
   assign w_full    = r_valid[r_wp];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      bop_range_cmp u_cmp (
         .i_valid    (r_valid[gi]),
         .i_entry    (r_entry[gi]),
         .i_addr     (lookup_addr_i),
         .i_wr_pair  (w_wr_pair),
         .o_in_range (w_in_range[gi]),
         .o_is_first (w_is_first[gi]),
         .o_dup      (w_dup[gi])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         r_wp    <= '0;
         r_count <= '0;
         r_evict <= '0;
         r_bad   <= 1'b0;
      end else if (flush_i) begin
         r_valid <= '0;
         r_wp    <= '0;
         r_count <= '0;
         r_evict <= '0;
         r_bad   <= 1'b0;
      end else begin
         if (wr_en_i && !w_ordered) begin
            r_bad <= 1'b1;
         end
         if (w_write) begin
            r_valid[r_wp] <= 1'b1;
            r_wp          <= r_wp + IDX_W'(1);
            if (w_full) begin
               if (r_evict != '1) begin
                  r_evict <= r_evict + BOP_EVICT_W'(1);
               end
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   // NOTE: interval storage carries no reset; the valid bits alone gate every use of it.
   always_ff @(posedge clk_i) begin
      if (w_write) begin
         r_entry[r_wp] <= w_wr_pair;
      end
   end

   // NOTE: blocking assignments here build a priority chain; scanning downward lets the lowest index win.
   always_comb begin
      w_hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_in_range[i]) begin
            w_hit_idx = IDX_W'(i);
         end
      end
   end

   assign in_range_o  = |w_in_range;
   assign is_first_o  = |w_is_first;
   assign hit_idx_o   = w_hit_idx;
   assign count_o     = r_count;
   assign evict_cnt_o = r_evict;
   assign bad_wr_o    = r_bad;

endmodule

// File: tb/tb_bop_interval_table.sv
// Directed test-plan steps plus randomized traffic, checked against a slot-array model.
module tb_bop_interval_table;

   localparam int DEPTH = 8;
   localparam int AW    = 32;

   logic          clk_i;
   logic          rst_ni;
   logic          flush_i;
   logic          wr_en_i;
   logic [AW-1:0] wr_first_i;
   logic [AW-1:0] wr_last_i;
   logic [AW-1:0] lookup_addr_i;
   logic          in_range_o;
   logic          is_first_o;
   logic [2:0]    hit_idx_o;
   logic [3:0]    count_o;
   logic [15:0]   evict_cnt_o;
   logic          bad_wr_o;

   bop_interval_table #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .wr_en_i       (wr_en_i),
      .wr_first_i    (wr_first_i),
      .wr_last_i     (wr_last_i),
      .lookup_addr_i (lookup_addr_i),
      .in_range_o    (in_range_o),
      .is_first_o    (is_first_o),
      .hit_idx_o     (hit_idx_o),
      .count_o       (count_o),
      .evict_cnt_o   (evict_cnt_o),
      .bad_wr_o      (bad_wr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: slots, write pointer and sticky/saturating counters.
   bit            m_valid [DEPTH];
   logic [AW-1:0] m_first [DEPTH];
   logic [AW-1:0] m_last  [DEPTH];
   int            m_wp;
   int            m_evict;
   bit            m_bad;

   // Observations taken at the most recent pre-edge sample point.
   logic       obs_ir, obs_if, obs_bad;
   logic [2:0] obs_idx;
   logic [3:0] obs_cnt;
   logic [15:0] obs_ev;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_wp = 0; m_evict = 0; m_bad = 1'b0;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   function automatic void model_write(input bit we, input bit fl,
                                       input logic [AW-1:0] f, input logic [AW-1:0] l);
      bit dup;
      if (fl) begin
         model_clear();
      end else if (we) begin
         if (f > l) begin
            m_bad = 1'b1;
         end else begin
            dup = 1'b0;
            for (int i = 0; i < DEPTH; i++)
               if (m_valid[i] && m_first[i] == f && m_last[i] == l) dup = 1'b1;
            if (!dup) begin
               if (m_valid[m_wp]) m_evict = (m_evict == 65535) ? 65535 : m_evict + 1;
               m_valid[m_wp] = 1'b1;
               m_first[m_wp] = f;
               m_last[m_wp]  = l;
               m_wp = (m_wp + 1) % DEPTH;
            end
         end
      end
   endfunction

   function automatic void model_lookup(input logic [AW-1:0] a, output bit ir, output bit isf,
                                        output int idx);
      ir = 1'b0; isf = 1'b0; idx = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i] && a >= m_first[i] && a <= m_last[i]) begin
            if (!ir) idx = i;
            ir = 1'b1;
         end
         if (m_valid[i] && a == m_first[i]) isf = 1'b1;
      end
   endfunction

   // One clock: drive, sample before the edge against the model, then advance the model.
   task automatic cycle(input bit we, input logic [AW-1:0] f, input logic [AW-1:0] l,
                        input bit fl, input logic [AW-1:0] a);
      bit e_ir, e_if;
      int e_idx;
      @(negedge clk_i);
      wr_en_i = we; wr_first_i = f; wr_last_i = l; flush_i = fl; lookup_addr_i = a;
      #1;
      model_lookup(a, e_ir, e_if, e_idx);
      obs_ir = in_range_o; obs_if = is_first_o; obs_idx = hit_idx_o;
      obs_cnt = count_o; obs_ev = evict_cnt_o; obs_bad = bad_wr_o;
      check("in_range", 64'(obs_ir), 64'(e_ir));
      check("is_first", 64'(obs_if), 64'(e_if));
      check("hit_idx", 64'(obs_idx), 64'(e_idx));
      check("count", 64'(obs_cnt), 64'(model_count()));
      check("evict_cnt", 64'(obs_ev), 64'(m_evict));
      check("bad_wr", 64'(obs_bad), 64'(m_bad));
      @(posedge clk_i);
      model_write(we, fl, f, l);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] f, l, a, base;
      int r;

      rst_ni = 1'b0; flush_i = 1'b0; wr_en_i = 1'b0;
      wr_first_i = '0; wr_last_i = '0; lookup_addr_i = '0;
      model_clear();
      #3;
      check("rst_in_range", 64'(in_range_o), 64'd0);
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_evict", 64'(evict_cnt_o), 64'd0);
      check("rst_bad", 64'(bad_wr_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Basic interval and its edges; same-cycle lookup must not see the write.
      cycle(1, 32'h1000, 32'h1010, 0, 32'h1000);
      check("tp1_no_bypass", 64'(obs_ir), 64'd0);
      cycle(0, 0, 0, 0, 32'h0FFF);
      check("tp1_below", 64'(obs_ir), 64'd0);
      check("tp1_count", 64'(obs_cnt), 64'd1);
      cycle(0, 0, 0, 0, 32'h1000);
      check("tp1_first_ir", 64'(obs_ir), 64'd1);
      check("tp1_first_if", 64'(obs_if), 64'd1);
      check("tp1_first_idx", 64'(obs_idx), 64'd0);
      cycle(0, 0, 0, 0, 32'h1010);
      check("tp1_last_ir", 64'(obs_ir), 64'd1);
      check("tp1_last_if", 64'(obs_if), 64'd0);
      cycle(0, 0, 0, 0, 32'h1011);
      check("tp1_above", 64'(obs_ir), 64'd0);

      cycle(1, 32'h2000, 32'h2003, 0, 32'h2001);
      check("tp2_same_cycle", 64'(obs_ir), 64'd0);
      cycle(0, 0, 0, 0, 32'h2001);
      check("tp2_next_cycle", 64'(obs_ir), 64'd1);

      // Duplicate suppression.
      cycle(0, 0, 0, 1, 0);
      cycle(1, 32'h3000, 32'h3020, 0, 0);
      cycle(1, 32'h3000, 32'h3020, 0, 0);
      cycle(1, 32'h3000, 32'h3021, 0, 0);
      check("tp3_dup_count", 64'(obs_cnt), 64'd1);
      cycle(0, 0, 0, 0, 32'h3021);
      check("tp3_count", 64'(obs_cnt), 64'd2);
      check("tp3_idx", 64'(obs_idx), 64'd1);

      // Wrap and eviction.
      cycle(0, 0, 0, 1, 0);
      for (int k = 1; k <= 9; k++) cycle(1, 32'(k) * 32'h100, 32'(k) * 32'h100 + 32'hF, 0, 0);
      cycle(0, 0, 0, 0, 32'h105);
      check("tp4_count", 64'(obs_cnt), 64'd8);
      check("tp4_evict", 64'(obs_ev), 64'd1);
      check("tp4_evicted", 64'(obs_ir), 64'd0);
      cycle(0, 0, 0, 0, 32'h905);
      check("tp4_wrap_ir", 64'(obs_ir), 64'd1);
      check("tp4_wrap_idx", 64'(obs_idx), 64'd0);

      // Bad write, then flush beating a simultaneous write.
      cycle(1, 32'h50, 32'h40, 0, 0);
      cycle(1, 32'h60, 32'h70, 1, 32'h905);
      check("tp5_bad", 64'(obs_bad), 64'd1);
      check("tp5_count_kept", 64'(obs_cnt), 64'd8);
      check("tp5_preflush_hit", 64'(obs_ir), 64'd1);
      cycle(0, 0, 0, 0, 32'h60);
      check("tp5_flush_count", 64'(obs_cnt), 64'd0);
      check("tp5_flush_bad", 64'(obs_bad), 64'd0);
      check("tp5_flush_evict", 64'(obs_ev), 64'd0);
      check("tp5_dropped_wr", 64'(obs_ir), 64'd0);

      // Top-of-address-space interval.
      cycle(1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0);
      cycle(0, 0, 0, 0, 32'hFFFF_FFFF);
      check("tp6_top", 64'(obs_ir), 64'd1);
      cycle(0, 0, 0, 0, 32'h0000_0000);
      check("tp6_zero", 64'(obs_ir), 64'd0);

      // Randomized traffic from a small address pool so hits, duplicates and evictions occur.
      for (int n = 0; n < 300; n++) begin
         r    = int'($urandom_range(0, 99));
         base = 32'($urandom_range(0, 15)) * 32'h40;
         f    = base;
         l    = base + 32'($urandom_range(0, 63));
         if (r >= 55 && r < 60) begin
            f = base + 32'h10;
            l = base;
         end
         a = ($urandom_range(0, 3) == 0) ? base : 32'($urandom_range(0, 32'h420));
         cycle(r < 60, f, l, r < 2, a);
      end

      // Asynchronous reset between clock edges.
      cycle(1, 32'h4000, 32'h4FFF, 0, 0);
      cycle(1, 32'h4800, 32'h4800, 0, 0);
      cycle(1, 32'h9, 32'h1, 0, 32'h4800);
      check("ar_pre_hit", 64'(obs_ir), 64'd1);
      @(negedge clk_i);
      wr_en_i = 1'b0; flush_i = 1'b0; lookup_addr_i = 32'h4800;
      #2;
      rst_ni = 1'b0;
      #1;
      model_clear();
      check("ar_in_range", 64'(in_range_o), 64'd0);
      check("ar_is_first", 64'(is_first_o), 64'd0);
      check("ar_hit_idx", 64'(hit_idx_o), 64'd0);
      check("ar_count", 64'(count_o), 64'd0);
      check("ar_evict", 64'(evict_cnt_o), 64'd0);
      check("ar_bad", 64'(bad_wr_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle(1, 32'h700, 32'h7FF, 0, 32'h4800);
      cycle(0, 0, 0, 0, 32'h700);
      check("ar_after_write", 64'(obs_ir), 64'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bop_interval_table.md
# bop_interval_table

Circular table of address intervals flagged as buffer overflows by the buffer-overflow protection unit. The protection unit writes a closed interval [first, last] when a tracked run of byte stores is classified as an overflow. Every cycle, the table answers a combinational lookup: is the current load/store virtual address inside any stored interval, and is it exactly an interval's first byte. The table sits directly downstream of the interval detector and feeds its load-checking logic.

## Interface
- DEPTH, 8, number of interval entries; power of two, ≥2
- AW, 32, address width in bits
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  invalidate all entries (context switch / crash handled)
- wr_en_i  in  1  single-cycle write strobe for one interval
- wr_first_i  in  AW  interval first byte address
- wr_last_i  in  AW  interval last byte address (inclusive)
- lookup_addr_i  in  AW  address under test
- in_range_o  out  1  lookup_addr_i within [first, last] of some valid entry
- is_first_o  out  1  lookup_addr_i equals first of some valid entry
- hit_idx_o  out  $clog2(DEPTH)  lowest-index matching entry; 0 when no hit
- count_o  out  $clog2(DEPTH)+1  number of valid entries
- evict_cnt_o  out  16  saturating count of entries overwritten while full
- bad_wr_o  out  1  sticky: a write with first > last was rejected

## Operation
- Storage per entry: valid bit, first, last. Write pointer wp indexes the next slot.
- Write accepted when wr_en_i=1, flush_i=0, and wr_first_i ≤ wr_last_i (unsigned):
  - If a valid entry already holds an identical (first, last) pair, nothing changes. This is duplicate suppression: no pointer move, no count change.
  - Otherwise, write the pair into slot wp, set it valid, and advance wp by 1 modulo DEPTH.
  - If slot wp was already valid (table full), the oldest entry is overwritten, count_o stays DEPTH, and evict_cnt_o increments (saturates at 16'hFFFF).
  - Otherwise count_o increments.
- Write with first > last: ignored; bad_wr_o set, cleared only by reset or flush.
- flush_i: all valid bits cleared; wp, count_o, evict_cnt_o, and bad_wr_o all go to 0. flush_i takes priority over a simultaneous wr_en_i, and the write is dropped.
- Lookup is purely combinational on the registered table state:
  - in_range_o = OR over valid entries of (first ≤ addr ≤ last), unsigned.
  - is_first_o = OR over valid entries of (addr == first).
  - hit_idx_o gives the lowest matching index by in_range priority.
- Comparisons are full AW-bit unsigned with no wrap across 0. An interval whose last is 0xFFFFFFFF is legal.

## Timing
- Reset values: all entries invalid, wp=0, in_range_o=0, is_first_o=0, hit_idx_o=0, count_o=0, evict_cnt_o=0, bad_wr_o=0.
- A write in cycle N is visible to lookup from cycle N+1. A same-cycle lookup sees the old contents, with no write-through bypass.
- A flush in cycle N produces no hits from cycle N+1. In cycle N itself, lookups still reflect the pre-flush state.
- Back-to-back writes are accepted every cycle, with no stall and no ready signal.
- Reset asserted mid-operation clears all state asynchronously. Outputs go to reset values immediately (combinational from cleared valids).
- count_o, evict_cnt_o, and bad_wr_o are registered and update one cycle after the causing write.

## Structure
- bop_pkg holds:
  - typedef bop_interval_t {logic [AW-1:0] first; logic [AW-1:0] last;}
  - constant BOP_TABLE_DEPTH = 8
  - constant BOP_EVICT_W = 16
- Sub-module bop_range_cmp: one per entry. Inputs are valid, interval, and addr. Outputs are in_range and is_first. Instantiate it in a generate loop. The same comparator also performs duplicate detection against the write pair.

## Test plan
- Reset, then write [0x1000, 0x1010]: lookup 0x0FFF -> in_range 0. 0x1000 -> in_range 1, is_first 1, hit_idx 0. 0x1010 -> in_range 1, is_first 0. 0x1011 -> 0. count_o=1.
- Same-cycle visibility: write [0x2000, 0x2003] while lookup=0x2001 -> in_range 0 in that cycle, 1 the next cycle.
- Duplicate: write [0x3000, 0x3020] twice -> count_o=1, wp=1. Then write [0x3000, 0x3021] -> count_o=2.
- Wrap/eviction with DEPTH=8: write 9 distinct intervals [0x100*k, 0x100*k+0xF] for k=1..9.
  - count_o=8, evict_cnt_o=1.
  - Lookup 0x105 -> 0 (evicted); lookup 0x905 -> 1 with hit_idx 0.
- Bad write and flush:
  - Write [0x50, 0x40] -> bad_wr_o=1, count_o unchanged.
  - Assert flush_i with a simultaneous wr_en_i [0x60, 0x70] -> next cycle count_o=0, bad_wr_o=0, lookup 0x60 -> 0.
- Boundary: write [0xFFFFFFF0, 0xFFFFFFFF] -> lookup 0xFFFFFFFF gives in_range 1, lookup 0x00000000 gives 0. Asynchronous reset mid-sequence clears all outputs without a clock edge.
